// File: rtl/riscv_multi_core.sv
// riscv_multi_core
// Multicycle RV32 integer core (RST/IF/ID/EX/MEM/WB/HALT) sitting between an
// external instruction memory and an external data memory, both accessed via
// req/ready handshakes.
//
// Supported: add, sub, mul (MUL_EN=1), addi, lui, lw, sw, beq, bne, blt, bge, jal.
// Fetching HALT_WORD stops the core cleanly; any other unsupported encoding
// stops it with `illegal` set.
//
// Ports
//   CLOCK_50     in   system clock (rising edge)
//   reset_n      in   asynchronous active-low reset
//   imem_req     out  fetch request (IF state)
//   imem_addr    out  fetch byte address (= PC), 0 when idle
//   imem_rdata   in   instruction word, valid with imem_ready
//   imem_ready   in   fetch complete
//   dmem_req     out  data access request (MEM state)
//   dmem_we      out  1 = store, 0 = load
//   dmem_addr    out  effective byte address, 0 when idle
//   dmem_wdata   out  store data (rs2), 0 unless storing
//   dmem_rdata   in   load data, valid with dmem_ready
//   dmem_ready   in   data access complete
//   done         out  core halted
//   illegal      out  halt was caused by an unsupported instruction
//   clock_count  out  cycles spent outside RST/HALT since reset (wraps)
//   instr_cnt    out  instructions that reached EX (wraps)
module riscv_multi_core #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter bit          MUL_EN    = 1'b1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_ready,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_ready,
    output logic                 done,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] clock_count,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_ADDI, OP_LUI, OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL, OP_ILL
    } op_t;

    state_t                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic signed [31:0]    a_q, a_d;
    logic signed [31:0]    b_q, b_d;
    logic [31:0]           target_q, target_d;
    logic [31:0]           alu_q, alu_d;
    logic [31:0]           mdr_q, mdr_d;
    logic                  illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]  clk_cnt_q, clk_cnt_d;
    logic [CNT_WIDTH-1:0]  instr_cnt_q, instr_cnt_d;
    logic [31:0]           regs_q [0:31];

    // Register-file write port, driven from EX (jal link) or WB
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [31:0]           rf_wdata;

    // Instruction fields and immediates, decoded from the held IR
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rs1, rs2, rd;
    logic signed [31:0]    imm_i, imm_s, imm_b, imm_j;
    logic signed [31:0]    rs1_val, rs2_val;
    op_t                   op;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // x0 always reads as zero regardless of array contents
    assign rs1_val = (rs1 == 5'd0) ? 32'sd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'sd0 : regs_q[rs2];

    always_comb begin
        op = OP_ILL;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000) begin
                    if (funct7 == 7'b0000000)               op = OP_ADD;
                    else if (funct7 == 7'b0100000)          op = OP_SUB;
                    else if (funct7 == 7'b0000001 && MUL_EN) op = OP_MUL;
                end
            end
            7'b0010011: if (funct3 == 3'b000) op = OP_ADDI;
            7'b0110111: op = OP_LUI;
            7'b0000011: if (funct3 == 3'b010) op = OP_LW;
            7'b0100011: if (funct3 == 3'b010) op = OP_SW;
            7'b1100011: begin
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    default: op = OP_ILL;
                endcase
            end
            7'b1101111: op = OP_JAL;
            default:    op = OP_ILL;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        target_d    = target_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        illegal_d   = illegal_q;
        clk_cnt_d   = clk_cnt_q;
        instr_cnt_d = instr_cnt_q;
        rf_we       = 1'b0;
        rf_waddr    = rd;
        rf_wdata    = alu_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;

        if (state_q != S_RST && state_q != S_HALT)
            clk_cnt_d = clk_cnt_q + CNT_WIDTH'(1);

        case (state_q)
            S_RST: state_d = S_IF;

            S_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_ID;
                end
            end

            S_ID: begin
                if (ir_q == HALT_WORD) begin
                    state_d = S_HALT;
                end else if (op == OP_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    a_d         = rs1_val;
                    b_d         = rs2_val;
                    // PC already points past this instruction
                    target_d    = (pc_q - 32'd4) + ((op == OP_JAL) ? imm_j : imm_b);
                    instr_cnt_d = instr_cnt_q + CNT_WIDTH'(1);
                    state_d     = S_EX;
                end
            end

            S_EX: begin
                state_d = S_IF;
                case (op)
                    OP_ADD:  begin alu_d = a_q + b_q;   state_d = S_WB; end
                    OP_SUB:  begin alu_d = a_q - b_q;   state_d = S_WB; end
                    OP_MUL:  begin alu_d = a_q * b_q;   state_d = S_WB; end
                    OP_ADDI: begin alu_d = a_q + imm_i; state_d = S_WB; end
                    OP_LUI:  begin alu_d = {ir_q[31:12], 12'b0}; state_d = S_WB; end
                    OP_LW:   begin alu_d = a_q + imm_i; state_d = S_MEM; end
                    OP_SW:   begin alu_d = a_q + imm_s; state_d = S_MEM; end
                    OP_BEQ:  if (a_q == b_q) pc_d = target_q;
                    OP_BNE:  if (a_q != b_q) pc_d = target_q;
                    OP_BLT:  if (a_q <  b_q) pc_d = target_q;
                    OP_BGE:  if (a_q >= b_q) pc_d = target_q;
                    OP_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q;
                        pc_d     = target_q;
                    end
                    default: state_d = S_IF;
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
                if (dmem_ready) begin
                    if (op == OP_SW) begin
                        state_d = S_IF;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                rf_we    = 1'b1;
                rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
                state_d  = S_IF;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RST;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            target_q    <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            illegal_q   <= 1'b0;
            clk_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            target_q    <= target_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            illegal_q   <= illegal_d;
            clk_cnt_q   <= clk_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Bus outputs are zero whenever the matching request is idle
    assign imem_addr   = imem_req ? pc_q  : '0;
    assign dmem_addr   = dmem_req ? alu_q : '0;
    assign dmem_wdata  = dmem_we  ? b_q   : '0;
    assign done        = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign clock_count = clk_cnt_q;
    assign instr_cnt   = instr_cnt_q;

endmodule

// File: tb/tb_riscv_multi_core.sv
// Scoreboarded bench for riscv_multi_core: directed programs are loaded into
// a behavioural instruction memory; every expected store is queued when the
// program is written and a monitor pops and compares on each completed store.
module tb_riscv_multi_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        done, illegal;
    logic [15:0] clock_count, instr_cnt;

    // Second core built without the multiplier; it only ever sees a mul word
    logic        nm_imem_req, nm_dmem_req, nm_dmem_we, nm_done, nm_illegal;
    logic [31:0] nm_imem_addr, nm_dmem_addr, nm_dmem_wdata;
    logic [15:0] nm_clock_count, nm_instr_cnt;
    logic [31:0] nm_word = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011};

    always #10 clk = ~clk;

    riscv_multi_core #(.CNT_WIDTH(16), .RESET_PC(32'h0), .HALT_WORD(32'hFFFF_FFFF), .MUL_EN(1'b1)) dut (
        .CLOCK_50(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .done(done), .illegal(illegal), .clock_count(clock_count), .instr_cnt(instr_cnt)
    );

    riscv_multi_core #(.CNT_WIDTH(16), .RESET_PC(32'h0), .HALT_WORD(32'hFFFF_FFFF), .MUL_EN(1'b0)) dut_nm (
        .CLOCK_50(clk), .reset_n(reset_n),
        .imem_req(nm_imem_req), .imem_addr(nm_imem_addr), .imem_rdata(nm_word), .imem_ready(1'b1),
        .dmem_req(nm_dmem_req), .dmem_we(nm_dmem_we), .dmem_addr(nm_dmem_addr), .dmem_wdata(nm_dmem_wdata),
        .dmem_rdata(32'h0), .dmem_ready(1'b0),
        .done(nm_done), .illegal(nm_illegal), .clock_count(nm_clock_count), .instr_cnt(nm_instr_cnt)
    );

    // Memory models with programmable wait states
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    int          ilat = 0, dlat = 0;
    int          icnt = 0, dcnt = 0;

    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_rdata = dmem[dmem_addr[9:2]];
    assign imem_ready = imem_req && (icnt == ilat);
    assign dmem_ready = dmem_req && (dcnt == dlat);

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr[9:2]] <= dmem_wdata;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    st_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: store scoreboard, request stability, and fetch tracking
    logic        hold_v = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    logic        seen14 = 1'b0;
    st_t         e_m;

    always @(negedge clk) begin
        if (dmem_req) begin
            if (hold_v) begin
                n_vec++;
                if (dmem_addr !== h_addr || dmem_wdata !== h_wdata || dmem_we !== h_we) begin
                    n_err++;
                    $display("FAIL dmem_hold: got addr %h wdata %h we %b, required %h %h %b",
                             dmem_addr, dmem_wdata, dmem_we, h_addr, h_wdata, h_we);
                end
            end
            hold_v  = !dmem_ready;
            h_addr  = dmem_addr;
            h_wdata = dmem_wdata;
            h_we    = dmem_we;
            if (dmem_we && dmem_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL store_unexpected: got addr %h data %h, required no store", dmem_addr, dmem_wdata);
                end else begin
                    e_m = exp_q.pop_front();
                    if (dmem_addr !== e_m.addr || dmem_wdata !== e_m.data) begin
                        n_err++;
                        $display("FAIL store: got addr %h data %h, required addr %h data %h",
                                 dmem_addr, dmem_wdata, e_m.addr, e_m.data);
                    end
                end
            end
        end else begin
            hold_v = 1'b0;
        end
        if (imem_req && imem_ready && imem_addr == 32'h14) seen14 = 1'b1;
    end

    // Tiny assembler
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        logic [31:0] i = imm;
        return {i[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] rtype(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        logic [31:0] i = imm;
        return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        logic [31:0] i = imm;
        return {i[11:0], 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
        logic [31:0] i = imm;
        return {i[12], i[10:5], 5'(rs2), 5'(rs1), f3, i[4:1], i[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int imm);
        logic [31:0] i = imm;
        return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'b1101111};
    endfunction

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [2:0]  F_BEQ = 3'b000, F_BNE = 3'b001, F_BLT = 3'b100, F_BGE = 3'b101;

    int wp;

    task automatic emit(input logic [31:0] w);
        imem[wp] = w;
        wp++;
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
        st_t s;
        s.addr = a;
        s.data = d;
        exp_q.push_back(s);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        wp = 0;
        exp_q.delete();
        ilat = 0;
        dlat = 0;
        seen14 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input int max);
        int c = 0;
        while (!done && c < max) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_done"}, {31'b0, done}, 32'd1);
        @(negedge clk);
        chk({name, "_stores_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Program 1: arithmetic, counts only
        hold_reset();
        chk("rst_imem_req",    {31'b0, imem_req}, 32'd0);
        chk("rst_dmem_req",    {31'b0, dmem_req}, 32'd0);
        chk("rst_done",        {31'b0, done}, 32'd0);
        chk("rst_illegal",     {31'b0, illegal}, 32'd0);
        chk("rst_clock_count", {16'b0, clock_count}, 32'd0);
        chk("rst_instr_cnt",   {16'b0, instr_cnt}, 32'd0);
        emit(addi(1, 0, 7));
        emit(addi(2, 0, -3));
        emit(rtype(7'b0000000, 3, 1, 2));
        emit(rtype(7'b0100000, 4, 1, 2));
        emit(rtype(7'b0000001, 5, 1, 2));
        emit(HALT);
        release_reset();
        #1 chk("rst_state_no_fetch", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("first_fetch_req",  {31'b0, imem_req}, 32'd1);
        chk("first_fetch_addr", imem_addr, 32'h0);
        wait_done("arith", 200);
        chk("arith_illegal",     {31'b0, illegal}, 32'd0);
        chk("arith_instr_cnt",   {16'b0, instr_cnt}, 32'd5);
        chk("arith_clock_count", {16'b0, clock_count}, 32'd22);
        chk("nomul_done",        {31'b0, nm_done}, 32'd1);
        chk("nomul_illegal",     {31'b0, nm_illegal}, 32'd1);
        chk("nomul_clock_count", {16'b0, nm_clock_count}, 32'd2);
        chk("nomul_instr_cnt",   {16'b0, nm_instr_cnt}, 32'd0);
        chk("nomul_no_req",      {30'b0, nm_imem_req, nm_dmem_req}, 32'd0);

        // Program 1b: same arithmetic, results stored out
        hold_reset();
        emit(addi(1, 0, 7));
        emit(addi(2, 0, -3));
        emit(rtype(7'b0000000, 3, 1, 2));
        emit(rtype(7'b0100000, 4, 1, 2));
        emit(rtype(7'b0000001, 5, 1, 2));
        emit(sw(3, 0, 0));
        emit(sw(4, 0, 4));
        emit(sw(5, 0, 8));
        emit(HALT);
        expect_store(32'h0, 32'd4);
        expect_store(32'h4, 32'd10);
        expect_store(32'h8, 32'hFFFF_FFEB);
        release_reset();
        wait_done("arith_st", 300);
        chk("arith_st_instr_cnt",   {16'b0, instr_cnt}, 32'd8);
        chk("arith_st_clock_count", {16'b0, clock_count}, 32'd34);

        // Program 2: store/load with 3 data wait states
        hold_reset();
        dlat = 3;
        emit(addi(1, 0, 7));
        emit(sw(1, 0, 8));
        emit(lw(6, 0, 8));
        emit(sw(6, 0, 12));
        emit(HALT);
        expect_store(32'h8, 32'd7);
        expect_store(32'hC, 32'd7);
        release_reset();
        wait_done("ldst", 300);
        chk("ldst_instr_cnt",   {16'b0, instr_cnt}, 32'd4);
        chk("ldst_clock_count", {16'b0, clock_count}, 32'd28);

        // Program 3: counted loop, then signed branches both ways
        hold_reset();
        emit(addi(1, 0, 0));          // 00
        emit(addi(2, 0, 5));          // 04
        emit(addi(1, 1, 1));          // 08
        emit(br(F_BLT, 1, 2, -4));    // 0C
        emit(sw(1, 0, 0));            // 10
        emit(addi(3, 0, -1));         // 14
        emit(addi(4, 0, 1));          // 18
        emit(br(F_BLT, 3, 4, 8));     // 1C taken
        emit(addi(5, 5, 1));
        emit(br(F_BGE, 3, 4, 8));     // 24 not taken
        emit(addi(5, 5, 2));
        emit(br(F_BGE, 4, 3, 8));     // 2C taken
        emit(addi(5, 5, 4));
        emit(br(F_BEQ, 3, 4, 8));     // 34 not taken
        emit(addi(5, 5, 8));
        emit(br(F_BEQ, 3, 3, 8));     // 3C taken
        emit(addi(5, 5, 16));
        emit(br(F_BNE, 3, 4, 8));     // 44 taken
        emit(addi(5, 5, 32));
        emit(br(F_BNE, 4, 4, 8));     // 4C not taken
        emit(addi(5, 5, 64));
        emit(sw(5, 0, 4));            // 54
        emit(HALT);
        expect_store(32'h0, 32'd5);
        expect_store(32'h4, 32'd74);
        release_reset();
        wait_done("branch", 500);
        chk("branch_instr_cnt",   {16'b0, instr_cnt}, 32'd26);
        chk("branch_clock_count", {16'b0, clock_count}, 32'd94);

        // Program 4: x0 hardwiring and jal, with 1 fetch wait state
        hold_reset();
        ilat = 1;
        emit(addi(0, 0, 5));          // 00
        emit(sw(0, 0, 0));            // 04
        emit(addi(9, 0, 1));          // 08
        emit(addi(9, 0, 2));          // 0C
        emit(jal(7, 8));              // 10
        emit(addi(9, 0, 3));          // 14 skipped
        emit(sw(7, 0, 4));            // 18
        emit(sw(9, 0, 8));            // 1C
        emit(HALT);                   // 20
        expect_store(32'h0, 32'd0);
        expect_store(32'h4, 32'h14);
        expect_store(32'h8, 32'd2);
        release_reset();
        wait_done("jal", 400);
        chk("jal_skipped_0x14",  {31'b0, seen14}, 32'd0);
        chk("jal_instr_cnt",     {16'b0, instr_cnt}, 32'd7);
        chk("jal_clock_count",   {16'b0, clock_count}, 32'd37);

        // Program 5: illegal opcode halts and freezes everything
        hold_reset();
        emit(addi(1, 0, 1));
        emit(32'h0000_007F);
        emit(addi(2, 0, 2));
        emit(HALT);
        release_reset();
        wait_done("ill", 100);
        chk("ill_illegal",     {31'b0, illegal}, 32'd1);
        chk("ill_instr_cnt",   {16'b0, instr_cnt}, 32'd1);
        chk("ill_clock_count", {16'b0, clock_count}, 32'd6);
        begin
            int fetches = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (imem_req || dmem_req) fetches++;
            end
            chk("ill_no_req_after_halt", fetches, 32'd0);
        end
        chk("ill_clock_frozen", {16'b0, clock_count}, 32'd6);
        chk("ill_instr_frozen", {16'b0, instr_cnt}, 32'd1);
        chk("ill_done_held",    {31'b0, done}, 32'd1);

        // Program 6: asynchronous reset in the middle of a stalled load
        hold_reset();
        dlat = 20;
        emit(lw(6, 0, 8));
        emit(HALT);
        release_reset();
        begin
            int c = 0;
            while (!dmem_req && c < 50) begin
                @(negedge clk);
                c++;
            end
        end
        chk("lw_req_seen", {31'b0, dmem_req}, 32'd1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_dmem_req",    {31'b0, dmem_req}, 32'd0);
        chk("rstmid_imem_req",    {31'b0, imem_req}, 32'd0);
        chk("rstmid_clock_count", {16'b0, clock_count}, 32'd0);
        chk("rstmid_instr_cnt",   {16'b0, instr_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid_refetch_req",  {31'b0, imem_req}, 32'd1);
        chk("rstmid_refetch_addr", imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_multi_core.md
# riscv_multi_core

Parametrised multicycle RV32 integer core. It succeeds the single-configuration matrix-program CPU and adds:

- external instruction and data memories behind req/ready handshakes;
- an asynchronous reset;
- a hardwired x0;
- a wider instruction subset (beq/bne/bge/jal);
- illegal-instruction halt;
- configurable counters.

It sits between the program memory and the matrix data memory, and reports `done`, cycle count and retired-instruction count to the board-level harness.

## Interface
Parameters:
- `CNT_WIDTH`, 16, width of `clock_count` and `instr_cnt`.
- `RESET_PC`, 32'h0, PC loaded on reset.
- `HALT_WORD`, 32'hFFFF_FFFF, fetched word that ends the program.
- `MUL_EN`, 1, when 1 `mul` is legal; when 0 `mul` is an illegal instruction.

Ports:
- `CLOCK_50`, in, 1, system clock, rising edge.
- `reset_n`, in, 1, asynchronous, active-low reset.
- `imem_req`, out, 1, fetch request.
- `imem_addr`, out, 32, byte address of the fetch (= PC).
- `imem_rdata`, in, 32, instruction word; valid when `imem_ready`=1.
- `imem_ready`, in, 1, fetch complete.
- `dmem_req`, out, 1, data access request.
- `dmem_we`, out, 1, 1 = store, 0 = load.
- `dmem_addr`, out, 32, effective byte address.
- `dmem_wdata`, out, 32, store data (rs2).
- `dmem_rdata`, in, 32, load data; valid when `dmem_ready`=1.
- `dmem_ready`, in, 1, access complete.
- `done`, out, 1, core halted.
- `illegal`, out, 1, the halt was caused by an unsupported instruction.
- `clock_count`, out, CNT_WIDTH, cycles since reset; stops at halt.
- `instr_cnt`, out, CNT_WIDTH, retired instructions.

## Operation
- States: RST, IF, ID, EX, MEM, WB, HALT.
- Reset state: RST; PC=RESET_PC; regs x1–x31, IR, counters, `done` and `illegal` all =0.
- RST -> IF unconditionally.
- IF:
  - `imem_req`=1, `imem_addr`=PC.
  - Holds until `imem_ready`=1; then IR<=`imem_rdata`, PC<=PC+4, -> ID.
- ID:
  - IR==HALT_WORD -> HALT with `illegal`=0.
  - Unsupported opcode/funct -> HALT with `illegal`=1.
  - Otherwise latch rs1/rs2 from the register file, compute target = (PC-4)+imm (B or J format, sign-extended), -> EX.
- EX, per instruction:
  - add/sub/mul/addi: ALUOut = result -> WB. `mul` keeps the low 32 bits; addi uses a sign-extended imm12.
  - lui: ALUOut = {imm20, 12'b0} -> WB.
  - lw/sw: address = rs1 + sext(imm12) -> MEM.
  - beq/bne/blt/bge: compare is signed; if taken, PC<=target. -> IF.
  - jal: rd<=PC (the link address), PC<=target. -> IF.
  - `instr_cnt` increments once per instruction on EX entry.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for sw; address and data are held stable.
  - Holds until `dmem_ready`=1. sw -> IF; lw latches MDR and -> WB.
- WB: rd<=ALUOut or MDR -> IF.
- x0: writes are discarded and reads return 0.
- Supported opcodes only: 0110011 (funct7 0000000/0100000/0000001, funct3 000), 0010011 (funct3 000), 0110111, 0000011 (funct3 010), 0100011 (funct3 010), 1100011 (funct3 000/001/100/101), 1101111.
- HALT:
  - `done`=1; no requests are issued; counters freeze.
  - Only reset exits HALT.
- `clock_count` increments every cycle outside RST and HALT, wrapping modulo 2^CNT_WIDTH. `instr_cnt` wraps the same way.
- Address alignment is not checked; the low 2 address bits are passed through unchanged.

## Timing
- `imem_req`, `dmem_req`, `dmem_we` and the address/data outputs are combinational decodes of the registered state/PC/ALUOut. They are all 0 during reset and in RST.
- Cycle counts with zero wait states (ready=1 in the request cycle):
  - ALU/lui: 4 cycles.
  - Branch/jal: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle (ready=0 while req=1) adds exactly one cycle. Outputs stay stable for the whole request.
- `ready` seen while `req`=0 is ignored.
- Asserting `reset_n`=0 in any state, including mid-handshake, drops the requests in the same cycle with no clock edge needed. There is no partial register write, and the PC returns to RESET_PC.
- HALT decode uses IR, so `done` rises 2 cycles after the HALT_WORD fetch completes.

## Test plan
- Arithmetic: program addi x1,x0,7; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2; mul x5,x1,x2; HALT_WORD -> required x3=4, x4=10, x5=-21, `instr_cnt`=5, `done`=1, `illegal`=0, `clock_count`=22.
- Load/store with waits: sw x1,8(x0) then lw x6,8(x0), with `dmem_ready` delayed 3 cycles each -> store seen with addr=8, wdata=7, held 4 cycles; x6=7; each access costs 3 extra cycles.
- Branch loop: x1=0, x2=5; loop body addi x1,x1,1; blt x1,x2,-4 -> exits with x1=5; blt is taken 4 times; bge/beq/bne checked both ways with a negative operand (-1 < 1 signed).
- jal and x0: jal x7,+8 at PC 0x10 -> x7=0x14, next fetch from 0x18. addi x0,x0,5 -> x0 reads 0.
- Illegal: opcode 0x7F word (or `mul` with MUL_EN=0) -> `done`=1, `illegal`=1, no further `imem_req`, counters frozen.
- Reset mid-lw: pull `reset_n` low while `dmem_req`=1 and `dmem_ready`=0 -> `dmem_req`=0 immediately, counters=0; after release, the first fetch is at RESET_PC.
